// File: rtl/sdm_sync_tx4.sv
// sdm_sync_tx4: clocked valid/ready to 1-of-4 four-phase RTZ link transmitter
module sdm_sync_tx4 #(
   parameter int DW   = 32,
   parameter int SYNC = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [DW/2-1:0] o0,
   output logic [DW/2-1:0] o1,
   output logic [DW/2-1:0] o2,
   output logic [DW/2-1:0] o3,
   input  logic            oa
);
   localparam int G = DW / 2;
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;
   state_t          state, state_n;
   logic [SYNC-1:0] sync;
   logic            ack_s;
   logic [DW-1:0]   mem [2];
   logic            wp, rp;
   logic [1:0]      cnt;
   logic            push, pop, clr, empty, full;
   logic [DW-1:0]   head;
   logic [G-1:0]    n0, n1, n2, n3;
   assign ack_s    = sync[SYNC-1];
   assign full     = cnt == 2'd2;
   assign empty    = cnt == 2'd0;
   assign in_ready = !full & !rst;
   assign push     = in_valid & in_ready;
   assign head     = mem[rp];
   // ack synchronizer chain; ack_s is its last stage
   always_ff @(posedge clk) begin
      if (rst) sync <= '0;
      else     sync <= {sync[SYNC-2:0], oa};
   end
   // 2-entry FIFO; a pop frees a slot only for the following edge
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (push) begin
            mem[wp] <= in_data;
            wp      <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end
   // handshake state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end
   // next state: data only launched while synchronized ack is low
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  if (!empty && !ack_s) state_n = S_DATA;
         S_DATA:  if (ack_s) state_n = S_NULL;
         S_NULL:  if (!ack_s) state_n = empty ? S_IDLE : S_DATA;
         default: state_n = S_IDLE;
      endcase
   end
   // outputs: pop/clear strobes and the 1-of-4 code of the FIFO head
   always_comb begin
      pop = (state == S_IDLE || state == S_NULL) && !ack_s && !empty;
      clr = state == S_DATA && ack_s;
      n0  = '0;
      n1  = '0;
      n2  = '0;
      n3  = '0;
      for (int i = 0; i < G; i++) begin
         n0[i] = head[2*i +: 2] == 2'd0;
         n1[i] = head[2*i +: 2] == 2'd1;
         n2[i] = head[2*i +: 2] == 2'd2;
         n3[i] = head[2*i +: 2] == 2'd3;
      end
   end
   // rail register drives the link directly so the rails never glitch
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         o0 <= '0;
         o1 <= '0;
         o2 <= '0;
         o3 <= '0;
      end else if (pop) begin
         o0 <= n0;
         o1 <= n1;
         o2 <= n2;
         o3 <= n3;
      end
   end
endmodule
